// File: rtl/uart_pkg.sv
// Shared types and limits for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int unsigned MIN_NBITS = 5;
    localparam int unsigned MAX_NBITS = 9;

    function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input logic [3:0] max_n);
        if (n < 4'(MIN_NBITS)) return 4'(MIN_NBITS);
        if (n > max_n)         return max_n;
        return n;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational read data; push/pop ignored when full/empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (!do_push && do_pop) level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Configurable UART transmitter fed by a valid/ready FIFO; frames are sent back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_data,
    input  logic [DIV_W-1:0]                  cfg_div,
    input  logic [3:0]                        cfg_nbits,
    input  logic [1:0]                        cfg_parity,
    input  logic                              cfg_stop2,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam logic [3:0] MAXN = 4'(DATA_W);

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rd;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (s_valid),
        .wr_data (s_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign s_ready = !fifo_full;

    tx_state_e         state_q, state_n;
    logic [DIV_W-1:0]  cnt_q, cnt_n, div_q, div_n;
    logic [3:0]        nbits_q, nbits_n, bitcnt_q, bitcnt_n;
    logic [DATA_W-1:0] sh_q, sh_n;
    logic              par_en_q, par_en_n, par_bit_q, par_bit_n;
    logic              stop2_q, stop2_n, tx_q, tx_n, busy_q, busy_n;

    logic [3:0]        nbits_c;
    logic [DATA_W-1:0] word_c;
    parity_e           par_c;
    logic              launch;

    // Word is masked to the clamped width so parity only covers transmitted bits.
    assign nbits_c = clamp_nbits(cfg_nbits, MAXN);
    assign word_c  = fifo_rd & ~({DATA_W{1'b1}} << nbits_c);
    assign par_c   = parity_e'(cfg_parity);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            nbits_q   <= '0;
            bitcnt_q  <= '0;
            sh_q      <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            div_q     <= div_n;
            nbits_q   <= nbits_n;
            bitcnt_q  <= bitcnt_n;
            sh_q      <= sh_n;
            par_en_q  <= par_en_n;
            par_bit_q <= par_bit_n;
            stop2_q   <= stop2_n;
            tx_q      <= tx_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        div_n     = div_q;
        nbits_n   = nbits_q;
        bitcnt_n  = bitcnt_q;
        sh_n      = sh_q;
        par_en_n  = par_en_q;
        par_bit_n = par_bit_q;
        stop2_n   = stop2_q;
        tx_n      = tx_q;
        busy_n    = busy_q;
        fifo_pop  = 1'b0;
        launch    = 1'b0;

        if (state_q != ST_IDLE && cnt_q != '0) begin
            cnt_n = cnt_q - DIV_W'(1);
        end else begin
            case (state_q)
                ST_IDLE: launch = !fifo_empty;
                ST_START: begin
                    state_n  = ST_DATA;
                    cnt_n    = div_q;
                    bitcnt_n = '0;
                    tx_n     = sh_q[0];
                end
                ST_DATA: begin
                    cnt_n = div_q;
                    if (bitcnt_q == nbits_q - 4'd1) begin
                        bitcnt_n = '0;
                        if (par_en_q) begin
                            state_n = ST_PARITY;
                            tx_n    = par_bit_q;
                        end else begin
                            state_n = ST_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        sh_n     = sh_q >> 1;
                        tx_n     = sh_q[1];
                        bitcnt_n = bitcnt_q + 4'd1;
                    end
                end
                ST_PARITY: begin
                    state_n = ST_STOP;
                    cnt_n   = div_q;
                    tx_n    = 1'b1;
                end
                ST_STOP: begin
                    // bitcnt marks the first of two stop periods.
                    if (stop2_q && bitcnt_q == '0) begin
                        bitcnt_n = 4'd1;
                        cnt_n    = div_q;
                    end else if (!fifo_empty) begin
                        launch = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                        tx_n    = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (launch) begin
            fifo_pop  = 1'b1;
            state_n   = ST_START;
            cnt_n     = cfg_div;
            div_n     = cfg_div;
            nbits_n   = nbits_c;
            sh_n      = word_c;
            par_en_n  = (par_c == PAR_EVEN) || (par_c == PAR_ODD);
            par_bit_n = (^word_c) ^ (par_c == PAR_ODD);
            stop2_n   = cfg_stop2;
            tx_n      = 1'b0;
            busy_n    = 1'b1;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, corner sequences and a per-clock reference model.
module tb_uart_tx_fifo;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [3:0]        cfg_nbits = 4'd8;
    logic [1:0]        cfg_parity = 2'b00;
    logic              cfg_stop2 = 1'b0;
    logic              tx;
    logic              busy;
    logic [LW-1:0]     fifo_level;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .cfg_div    (cfg_div),
        .cfg_nbits  (cfg_nbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of words and a per-clock list of expected line levels.
    logic [DATA_W-1:0] mq[$];
    logic              wave[$];
    logic              m_tx, m_busy, m_ready_pre;

    function automatic void build_frame(input logic [DATA_W-1:0] w, input logic [3:0] nb,
                                        input logic [1:0] p, input logic s2, input logic [DIV_W-1:0] d);
        logic bits[$];
        logic par;
        int   n;
        n = (nb < 5) ? 5 : ((nb > DATA_W) ? DATA_W : int'(nb));
        par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(w[i]);
            par ^= w[i];
        end
        if (p == 2'b01) bits.push_back(par);
        if (p == 2'b10) bits.push_back(~par);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[i])
            for (int r = 0; r <= int'(d); r++) wave.push_back(bits[i]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            wave.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else begin
            m_ready_pre = (mq.size() < DEPTH);
            if (wave.size() == 0 && mq.size() > 0)
                build_frame(mq.pop_front(), cfg_nbits, cfg_parity, cfg_stop2, cfg_div);
            if (wave.size() > 0) begin
                m_tx   = wave.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
            if (s_valid && m_ready_pre) mq.push_back(s_data);
        end
        #1;
        check("model", {26'd0, tx, busy, s_ready, fifo_level},
              {26'd0, m_tx, m_busy, (mq.size() < DEPTH) ? 1'b1 : 1'b0, LW'(mq.size())});
    end

    typedef struct {
        logic [DATA_W-1:0] word;
        logic [3:0]        nbits;
        logic [1:0]        par;
        logic              stop2;
        logic [DIV_W-1:0]  div;
        logic [15:0]       seq;
        int                len;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [15:0] s2b(input string s);
        logic [15:0] b = '0;
        for (int i = 0; i < s.len(); i++) b[i] = (s[i] == "1");
        return b;
    endfunction

    task automatic wait_idle(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy && fifo_level == '0) break;
        end
        check("idle wait", {31'd0, (i < limit) ? 1'b1 : 1'b0}, 32'd1);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    initial begin
        int mism, n;

        vecs[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, 16'd3, s2b("0101001011"),  10};
        vecs[1] = '{8'h41, 4'd7,  2'b01, 1'b1, 16'd1, s2b("01000001011"), 11};
        vecs[2] = '{8'h41, 4'd7,  2'b10, 1'b1, 16'd1, s2b("01000001111"), 11};
        vecs[3] = '{8'h3C, 4'd12, 2'b00, 1'b0, 16'd0, s2b("0001111001"),  10};
        vecs[4] = '{8'h3C, 4'd9,  2'b00, 1'b0, 16'd0, s2b("0001111001"),  10};
        vecs[5] = '{8'hFF, 4'd3,  2'b10, 1'b0, 16'd2, s2b("01111101"),    8};
        vecs[6] = '{8'h2A, 4'd6,  2'b11, 1'b1, 16'd0, s2b("001010111"),   9};

        repeat (3) @(negedge clk);
        check("reset state", {26'd0, tx, busy, s_ready, fifo_level}, {26'd0, 1'b1, 1'b0, 1'b1, LW'(0)});
        rst = 1'b0;

        foreach (vecs[v]) begin
            wait_idle(2000);
            cfg_div    = vecs[v].div;
            cfg_nbits  = vecs[v].nbits;
            cfg_parity = vecs[v].par;
            cfg_stop2  = vecs[v].stop2;
            push_word(vecs[v].word);
            mism = 0;
            for (int k = 0; k < vecs[v].len * (int'(vecs[v].div) + 1); k++) begin
                @(posedge clk);
                #1;
                if (tx !== vecs[v].seq[k / (int'(vecs[v].div) + 1)] || busy !== 1'b1) mism++;
            end
            check($sformatf("vec%0d wave", v), mism, 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d end", v), {30'd0, tx, busy}, {30'd0, 2'b10});
        end

        // Six back-to-back pushes into a depth-4 FIFO: the sixth is refused.
        wait_idle(2000);
        cfg_div = 16'd15; cfg_nbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("full ready", {31'd0, s_ready}, 32'd0);
                check("full level", {29'd0, fifo_level}, 32'd4);
            end
            s_valid = 1'b1;
            s_data  = DATA_W'(8'h30 + i);
        end
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("b2b busy run", n, 796);

        // Reset mid-frame with two words still queued.
        wait_idle(2000);
        cfg_div = 16'd3;
        @(negedge clk); s_valid = 1'b1; s_data = 8'hFF;
        @(negedge clk); s_data = 8'h11;
        @(negedge clk); s_data = 8'h22;
        @(negedge clk); s_valid = 1'b0;
        check("pre-rst level", {29'd0, fifo_level}, 32'd2);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst abort", {26'd0, tx, busy, s_ready, fifo_level}, {26'd0, 1'b1, 1'b0, 1'b1, LW'(0)});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mism = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) mism++;
        end
        check("post-rst quiet", mism, 0);

        // Config changed mid-frame: 3x10 clocks then 2x11 clocks.
        cfg_div = 16'd2; cfg_nbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        @(negedge clk); s_valid = 1'b1; s_data = 8'h5A;
        @(negedge clk); s_data = 8'hC3;
        @(negedge clk); s_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            if (n == 8) begin
                cfg_div    = 16'd1;
                cfg_parity = 2'b01;
            end
            @(negedge clk);
        end
        check("cfg change run", n, 52);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s_valid = ($urandom_range(0, 2) == 0);
            s_data  = DATA_W'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                cfg_div    = DIV_W'($urandom_range(0, 3));
                cfg_nbits  = 4'($urandom_range(0, 15));
                cfg_parity = 2'($urandom_range(0, 3));
                cfg_stop2  = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        wait_idle(2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
